// File: rtl/alu_seg_pkg.sv
// -----------------------------------------------------------------------------
// alu_seg_pkg
// Shared definitions for the registered ALU-to-seven-segment block:
//   - opcode encodings OP_ABSDIFF .. OP_XOR
//   - FSM state encodings for the operation handshake
//   - the active-high hex glyph table (bit0=a .. bit6=g, dp not included)
// -----------------------------------------------------------------------------
package alu_seg_pkg;

  // Opcodes, captured together with the operands.
  localparam logic [2:0] OP_ABSDIFF = 3'd0;  // |A-B|
  localparam logic [2:0] OP_ADD     = 3'd1;  // A+B, carry out
  localparam logic [2:0] OP_XNOR    = 3'd2;  // ~(A^B)
  localparam logic [2:0] OP_NAND    = 3'd3;  // ~(A&B)
  localparam logic [2:0] OP_SUB     = 3'd4;  // A-B, borrow out
  localparam logic [2:0] OP_AND     = 3'd5;
  localparam logic [2:0] OP_OR      = 3'd6;
  localparam logic [2:0] OP_XOR     = 3'd7;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for an operation
    ST_EXEC = 2'd1,  // operands held, result being registered
    ST_SHOW = 2'd2   // result just latched, res_valid pulse
  } state_t;

  // Hex glyphs 0..F, active-high, bit0=a .. bit6=g.
  // NOTE: this is a constant lookup, not a storage array, so it has no reset.
  localparam logic [6:0] GLYPH_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
  };

endpackage

// File: rtl/hex2sevensegment.sv
// -----------------------------------------------------------------------------
// hex2sevensegment
// Combinational nibble to seven-segment decoder.
// Ports:
//   nibble   [3:0]  hex digit to display
//   segments [6:0]  active-high segments, bit0=a .. bit6=g
// -----------------------------------------------------------------------------
module hex2sevensegment
  import alu_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = GLYPH_TABLE[nibble];

endmodule

// File: rtl/alu_seg_scan.sv
// -----------------------------------------------------------------------------
// alu_seg_scan
// Registered WIDTH-bit ALU with a valid/ready operand handshake, driving a
// time-multiplexed bank of WIDTH/4 hex digits (shared segment bus, one
// active-low anode strobe per digit).
//
// Parameters:
//   WIDTH     operand/result width, multiple of 4, at least 4
//   SCAN_DIV  clk cycles each digit stays lit, at least 1
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_1/in_2  operands A/B
//   sel        opcode, captured with the operands
//   in_valid   operands/opcode valid
//   in_ready   block can accept a new operation
//   res_valid  one-cycle pulse when a new result is latched
//   En         display enable, 0 blanks the display
//   seg        segments, bit0=a .. bit6=g, bit7=dp, active-high
//   an         digit strobes, active-low one-hot, an[0] = least significant
//
// Build option:
//   LEADING_ZERO_BLANK_EN  blank digits above 0 whose nibble and all higher
//                          nibbles are zero (dp on the top digit still shows
//                          the carry).
// -----------------------------------------------------------------------------
module alu_seg_scan
  import alu_seg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_1,
  input  logic [WIDTH-1:0]     in_2,
  input  logic [2:0]           sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 res_valid,
  input  logic                 En,
  output logic [7:0]           seg,
  output logic [WIDTH/4-1:0]   an
);

  localparam int NUM_DIGITS = WIDTH / 4;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Operation path
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] result;
  logic             carry;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  // One extra bit captures the add carry and the subtract borrow.
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_sel)
      OP_ABSDIFF: alu_res = diff_ext[WIDTH] ? (op_b - op_a) : diff_ext[WIDTH-1:0];
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_XNOR: alu_res = ~(op_a ^ op_b);
      OP_NAND: alu_res = ~(op_a & op_b);
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      default: alu_res = '0;
    endcase
  end

  // Handshake FSM. in_ready is high in IDLE and SHOW, so an accept can only
  // happen there; anything presented during EXEC is ignored.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      result    <= '0;
      carry     <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a     <= in_1;
            op_b     <= in_2;
            op_sel   <= sel;
            in_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result    <= alu_res;
          carry     <= alu_carry;
          res_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= ST_SHOW;
        end
        ST_SHOW: begin
          if (in_valid) begin
            op_a     <= in_1;
            op_b     <= in_2;
            op_sel   <= sel;
            in_ready <= 1'b0;
            state    <= ST_EXEC;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]      prescale;
  logic [IDX_W-1:0]      digit_idx;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic [6:0]            glyph_shown;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign nibble = result[4*digit_idx +: 4];

  hex2sevensegment u_hex2seg (
    .nibble   (nibble),
    .segments (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every nibble above it are zero.
  // Digit 0 always shows its glyph so a zero result still reads "0".
  logic leading_zero;
  assign leading_zero = (digit_idx != '0) && ((result >> (4*digit_idx)) == '0);
  assign glyph_shown  = leading_zero ? 7'h00 : glyph;
`else
  assign glyph_shown = glyph;
`endif

  // The decimal point on the top digit is the carry/borrow indicator.
  assign dp_next = (digit_idx == IDX_LAST) ? carry : 1'b0;

  always_comb begin
    an_next            = '1;
    an_next[digit_idx] = 1'b0;
  end

  // Scanning keeps running while blanked so re-enabling resumes at the
  // current digit; the output register lags the index by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale  <= '0;
      digit_idx <= '0;
      seg       <= 8'h00;
      an        <= '1;
    end else begin
      if (prescale == PRE_LAST) begin
        prescale  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end

      if (En) begin
        seg <= {dp_next, glyph_shown};
        an  <= an_next;
      end else begin
        seg <= 8'h00;
        an  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_alu_seg_scan
// Two instances: an 8-bit ALU (2 digits) and a 16-bit ALU (4 digits), both
// with a 3-cycle scan so the display can be observed quickly. Expected
// results are queued when an operation is issued; monitors pop and compare
// on every res_valid pulse, including the cycle the pulse arrives in.
// -----------------------------------------------------------------------------
module tb_alu_seg_scan;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [15:0] res;
    logic        carry;
    int          cyc;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] s;
    logic [7:0] r;
    logic       c;
  } vec8_t;

  // Hand-computed ALU vectors for the 8-bit instance.
  localparam vec8_t VEC8 [12] = '{
    '{8'h3C, 8'h5A, 3'd0, 8'h1E, 1'b0},  // |A-B|, B larger
    '{8'hF0, 8'h20, 3'd1, 8'h10, 1'b1},  // add with carry out
    '{8'h05, 8'h07, 3'd4, 8'hFE, 1'b1},  // sub with borrow
    '{8'hAA, 8'hAA, 3'd2, 8'hFF, 1'b0},  // xnor equal
    '{8'hF0, 8'h3C, 3'd3, 8'hCF, 1'b0},  // nand
    '{8'hF0, 8'h3C, 3'd5, 8'h30, 1'b0},  // and
    '{8'hF0, 8'h3C, 3'd6, 8'hFC, 1'b0},  // or
    '{8'hF0, 8'h3C, 3'd7, 8'hCC, 1'b0},  // xor
    '{8'h55, 8'h55, 3'd0, 8'h00, 1'b0},  // |A-B| equal
    '{8'h07, 8'h05, 3'd4, 8'h02, 1'b0},  // sub no borrow
    '{8'hFF, 8'h01, 3'd1, 8'h00, 1'b1},  // add wraps to zero
    '{8'h12, 8'h34, 3'd0, 8'h22, 1'b0}   // |A-B|
  };

  localparam logic [3:0] SCAN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit instance signals
  logic        rst8, iv8, ir8, rv8, en8;
  logic [7:0]  a8, b8, seg8;
  logic [2:0]  sel8;
  logic [1:0]  an8;

  // 16-bit instance signals
  logic        rst16, iv16, ir16, rv16, en16;
  logic [15:0] a16, b16;
  logic [7:0]  seg16;
  logic [2:0]  sel16;
  logic [3:0]  an16;

  exp_t q8[$];
  exp_t q16[$];

  alu_seg_scan #(.WIDTH(8), .SCAN_DIV(3)) u_dut8 (
    .clk(clk), .rst(rst8), .in_1(a8), .in_2(b8), .sel(sel8),
    .in_valid(iv8), .in_ready(ir8), .res_valid(rv8), .En(en8),
    .seg(seg8), .an(an8)
  );

  alu_seg_scan #(.WIDTH(16), .SCAN_DIV(3)) u_dut16 (
    .clk(clk), .rst(rst16), .in_1(a16), .in_2(b16), .sel(sel16),
    .in_valid(iv16), .in_ready(ir16), .res_valid(rv16), .En(en16),
    .seg(seg16), .an(an16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rv8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("res8_spurious", 32'(rv8), 32'd0);
      end else begin
        automatic exp_t e = q8.pop_front();
        check("res8_value",   32'(u_dut8.result), 32'(e.res));
        check("res8_carry",   32'(u_dut8.carry),  32'(e.carry));
        check("res8_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rv16 === 1'b1) begin
      if (q16.size() == 0) begin
        check("res16_spurious", 32'(rv16), 32'd0);
      end else begin
        automatic exp_t e = q16.pop_front();
        check("res16_value",   32'(u_dut16.result), 32'(e.res));
        check("res16_carry",   32'(u_dut16.carry),  32'(e.carry));
        check("res16_latency", cyc, e.cyc);
      end
    end
  end

  // Present one operation; the pulse is due two cycles after the drive point.
  task automatic issue8(input vec8_t v);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 20 && ir8 !== 1'b1; i++) @(negedge clk);
    a8 = v.a; b8 = v.b; sel8 = v.s; iv8 = 1'b1;
    e.res = 16'(v.r); e.carry = v.c; e.cyc = cyc + 2;
    q8.push_back(e);
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                         input logic [15:0] r, input logic c);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 20 && ir16 !== 1'b1; i++) @(negedge clk);
    a16 = a; b16 = b; sel16 = s; iv16 = 1'b1;
    e.res = r; e.carry = c; e.cyc = cyc + 2;
    q16.push_back(e);
    @(negedge clk);
    iv16 = 1'b0;
  endtask

  task automatic drain(input bit wide);
    for (int i = 0; i < 40 && (wide ? q16.size() : q8.size()) != 0; i++) @(negedge clk);
    if (wide) check("drain16", q16.size(), 0);
    else      check("drain8",  q8.size(),  0);
    @(negedge clk);
  endtask

  task automatic scan_check8(input string tag, input logic [7:0] exp_d1, input logic [7:0] exp_d0);
    logic [1:0] seen;
    seen = '0;
    for (int i = 0; i < 20 && seen != 2'b11; i++) begin
      @(negedge clk);
      if (an8 == 2'b10) begin
        check({tag, "_d0"}, 32'(seg8), 32'(exp_d0));
        seen[0] = 1'b1;
      end else if (an8 == 2'b01) begin
        check({tag, "_d1"}, 32'(seg8), 32'(exp_d1));
        seen[1] = 1'b1;
      end else begin
        check({tag, "_an"}, 32'(an8), 32'(2'b10));
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'(2'b11));
  endtask

  task automatic scan_check16(input string tag, input logic [3:0][7:0] exp_d);
    logic [3:0] seen;
    int d;
    seen = '0;
    for (int i = 0; i < 40 && seen != 4'hF; i++) begin
      @(negedge clk);
      case (an16)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d < 0) begin
        check({tag, "_an"}, 32'(an16), 32'(4'b1110));
      end else begin
        check($sformatf("%s_d%0d", tag, d), 32'(seg16), 32'(exp_d[d]));
        seen[d] = 1'b1;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [7:0] blank0;
    int d;

    rst8 = 1'b1; rst16 = 1'b1;
    iv8 = 1'b0;  iv16 = 1'b0;
    en8 = 1'b1;  en16 = 1'b1;
    a8 = '0; b8 = '0; sel8 = '0;
    a16 = '0; b16 = '0; sel16 = '0;
    blank0 = LZB ? 8'h00 : 8'h3F;  // an upper zero digit

    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst8_ready",  32'(ir8),  32'd1);
    check("rst8_valid",  32'(rv8),  32'd0);
    check("rst8_seg",    32'(seg8), 32'h00);
    check("rst8_an",     32'(an8),  32'h3);
    check("rst16_ready", 32'(ir16), 32'd1);
    check("rst16_seg",   32'(seg16), 32'h00);
    check("rst16_an",    32'(an16), 32'hF);

    // Scan sequence from reset on the 16-bit instance, with En dropped for
    // the edge of cycle 16 only. Result is zero, carry zero.
    rst8 = 1'b0; rst16 = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      en16 = (k != 16);
      @(negedge clk);
      d = ((k - 1) / 3) % 4;
      exp_an  = (k == 16) ? 4'hF  : SCAN_PAT[d];
      exp_seg = (k == 16) ? 8'h00 : ((d == 0) ? 8'h3F : blank0);
      check($sformatf("scan_an_k%0d", k),  32'(an16),  32'(exp_an));
      check($sformatf("scan_seg_k%0d", k), 32'(seg16), 32'(exp_seg));
    end
    en16 = 1'b1;

    // All eight opcodes plus boundaries on the 8-bit instance.
    for (int i = 0; i < 12; i++) begin
      issue8(VEC8[i]);
      drain(1'b0);
    end

    // Carry shown as dp on the top digit: 0xF0 + 0x20 = 0x10, carry 1.
    issue8(VEC8[1]);
    drain(1'b0);
    scan_check8("disp8_carry", 8'h86, 8'h3F);

    // Back-to-back: in_valid held for 6 cycles, operands change every
    // cycle; only cycles 0, 2, 4 are accepted.
    @(negedge clk);
    check("b2b_ready", 32'(ir8), 32'd1);
    begin
      exp_t e;
      int k0;
      k0 = cyc;
      e.carry = 1'b0;
      e.res = 16'h0002; e.cyc = k0 + 2; q8.push_back(e);
      e.res = 16'h000D; e.cyc = k0 + 4; q8.push_back(e);
      e.res = 16'h00FF; e.cyc = k0 + 6; q8.push_back(e);
      iv8 = 1'b1;
      a8 = 8'h01; b8 = 8'h01; sel8 = 3'd1; @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; sel8 = 3'd1; @(negedge clk);
      a8 = 8'h10; b8 = 8'h03; sel8 = 3'd4; @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; sel8 = 3'd7; @(negedge clk);
      a8 = 8'h0F; b8 = 8'hF0; sel8 = 3'd6; @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; sel8 = 3'd1; @(negedge clk);
      iv8 = 1'b0;
    end
    drain(1'b0);
    repeat (4) @(negedge clk);

    // 16-bit result 0x0042: leading zero digits blank when enabled.
    issue16(16'h0040, 16'h0002, 3'd6, 16'h0042, 1'b0);
    drain(1'b1);
    scan_check16("disp16_42", {blank0, blank0, 8'h66, 8'h5B});

    // 0xFFFF + 1 = 0x0000 with carry: dp stays lit on the top digit.
    issue16(16'hFFFF, 16'h0001, 3'd1, 16'h0000, 1'b1);
    drain(1'b1);
    scan_check16("disp16_cy", {(LZB ? 8'h80 : 8'hBF), blank0, blank0, 8'h3F});

    // Reset while in EXEC: no pulse, result and carry cleared.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; sel16 = 3'd1; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    rst16 = 1'b1;
    @(negedge clk);
    check("rstx_valid",  32'(rv16), 32'd0);
    check("rstx_ready",  32'(ir16), 32'd1);
    check("rstx_an",     32'(an16), 32'hF);
    check("rstx_result", 32'(u_dut16.result), 32'd0);
    check("rstx_carry",  32'(u_dut16.carry),  32'd0);
    rst16 = 1'b0;
    repeat (4) @(negedge clk);

    // Recovery after the aborted operation.
    issue16(16'h1234, 16'h1111, 3'd4, 16'h0123, 1'b0);
    drain(1'b1);
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seg_scan.md
Name: alu_seg_scan

Overview:
- Parametrised, registered successor to the team's 4-bit ALU-to-seven-segment path.
- Accepts two WIDTH-bit operands and a 3-bit opcode through a valid/ready handshake, computes one of 8 operations, and holds the result.
- Drives a time-multiplexed bank of WIDTH/4 hex digits with one shared segment bus and per-digit anode strobes.
- Sits between the switch/button front-end and the board's multi-digit 7-segment display.

Parameters:
- WIDTH, 8: operand/result width. Must be a multiple of 4 and at least 4. Local NUM_DIGITS = WIDTH/4.
- SCAN_DIV, 50000: clk cycles each digit stays lit. Must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_1  in  WIDTH  operand A.
- in_2  in  WIDTH  operand B.
- sel  in  3  opcode, captured with the operands.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept a new operation.
- res_valid  out  1  one-cycle pulse when a new result is latched.
- En  in  1  display enable; 0 blanks the display.
- seg  out  8  segments; bit0=a .. bit6=g, bit7=dp; active-high (1 = lit).
- an  out  NUM_DIGITS  digit strobes; active-low, one-hot-low; an[0] = least significant digit.

Behaviour:
- Reset values:
  - FSM in IDLE; in_ready=1; res_valid=0.
  - Operand, opcode, result and carry registers all 0.
  - Scan prescaler 0; digit index 0; seg=8'h00; an all ones.
- FSM states:
  - IDLE: in_ready=1. in_valid=1 captures in_1, in_2 and sel, then goes to EXEC.
  - EXEC: in_ready=0. Result and carry registered, then goes to SHOW.
  - SHOW: res_valid=1 for this cycle only; in_ready=1. in_valid=1 captures again and goes to EXEC; otherwise goes to IDLE.
- Latency: handshake accepted at edge N; result and carry updated at edge N+1; res_valid high in the cycle after edge N+1. Sustained throughput is one operation per 2 cycles.
- in_valid while in_ready=0 is ignored; the operands are not captured.
- Opcodes (all WIDTH bits wide):
  - 0: |A-B|; result 0 when A==B.
  - 1: A+B mod 2^WIDTH; carry = bit WIDTH of the sum.
  - 2: ~(A^B).
  - 3: ~(A&B).
  - 4: A-B mod 2^WIDTH; carry = borrow (A<B).
  - 5: A&B.
  - 6: A|B.
  - 7: A^B.
  - carry=0 for every opcode except 1 and 4.
- Display scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On the wrap cycle the digit index advances (NUM_DIGITS-1 wraps to 0).
  - Scanning runs regardless of En and of FSM state.
- Display output, registered (one cycle behind the digit index):
  - an: bit[index]=0, all other bits 1.
  - seg[6:0]: hex glyph of result[4*index+3 : 4*index].
  - seg[7] (dp): equals carry on digit NUM_DIGITS-1; 0 on all other digits.
- En=0: seg=8'h00 and an all ones on the next edge. The result and the scan index are preserved.
- A new result appears on the display from the next scan output register update; no glitch resync is performed.
- Reset during EXEC: the operation is discarded and no res_valid is issued.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined: any digit above index 0 whose nibble and all higher nibbles are 0 gets seg=8'h00 and its anode still strobed. Exception: dp stays on if carry=1 on the top digit. Digit 0 always shows its glyph.
- When undefined: every digit shows its glyph, zeros included.

Decomposition:
- Package alu_seg_pkg holds:
  - opcode localparams OP_ABSDIFF..OP_XOR (3'd0..3'd7);
  - FSM state encodings ST_IDLE, ST_EXEC, ST_SHOW;
  - the 16-entry active-high glyph constant table (0..F, dp excluded).
- One sub-module: the existing hex2sevensegment nibble decoder, instantiated once on the muxed nibble. Its output is remapped to the bit order above if needed.

Test Plan:
- WIDTH=8: A=8'h3C, B=8'h5A, sel=0 -> result 8'h1E, res_valid pulse exactly 2 cycles after accept, carry=0.
- sel=1, A=8'hF0, B=8'h20 -> result 8'h10, carry=1. When an[1]=0, seg[7]=1 and seg[6:0]=glyph '1'.
- sel=4, A=8'h05, B=8'h07 -> result 8'hFE, carry=1. sel=2, A=B=8'hAA -> result 8'hFF.
- SCAN_DIV=3, WIDTH=16: an sequence 1110,1101,1011,0111,1110, each held 3 cycles. Drop En -> seg=0, an=1111 next cycle; raise En -> scan resumes at the current index.
- Back-to-back in_valid held high for 6 cycles -> exactly 3 captures. Inputs changed while in_ready=0 are not captured.
- rst asserted in EXEC -> no res_valid; result=0, in_ready=1 next cycle, an all ones. With LEADING_ZERO_BLANK_EN and result 16'h0042: digits 3..2 blank, digits 1..0 show '4','2'.
